// File: rtl/arb_pkg.sv
// Shared types and constants for the SRAM write-side bank arbiter.
// Optional feature macro used by the arbiter: SRAM_ARB_WATCHDOG_EN.
package arb_pkg;

  localparam int PORT_NUM    = 16;
  localparam int SRAM_NUM    = 32;
  localparam int PAGE_CNT_W  = 12;
  localparam int PKT_PAGES_W = 6;
  localparam int PORT_IDX_W  = $clog2(PORT_NUM);
  localparam int SRAM_IDX_W  = $clog2(SRAM_NUM);

  // Watchdog: a lock held this many cycles past its grant edge is force-cleared
  // on the following edge, giving 255 locked cycles in total.
  localparam int                WDOG_W    = 8;
  localparam logic [WDOG_W-1:0] WDOG_LAST = 8'd254;

  // Bank selection policy; encoding 3 behaves like MATCH_MAXFREE.
  typedef enum logic [1:0] {
    MATCH_STATIC  = 2'd0,
    MATCH_MAXFREE = 2'd1,
    MATCH_RR      = 2'd2
  } match_mode_e;

  // A header announcing zero pages still needs one page of room.
  function automatic logic [PAGE_CNT_W-1:0] pages_needed(input logic [PKT_PAGES_W-1:0] pages);
    return (pages == '0) ? PAGE_CNT_W'(1) : PAGE_CNT_W'(pages);
  endfunction

endpackage

// File: rtl/sram_bank_select.sv
// Combinational candidate picker: given the port under test, its page need,
// the bank free counts and the registered lock vector, choose one bank.
// Round-robin scanning assumes BANK_NUM is a power of two.
module sram_bank_select
  import arb_pkg::*;
#(
  parameter int BANK_NUM = SRAM_NUM,
  parameter int PORT_W   = PORT_IDX_W
) (
  input  logic [1:0]                       mode_i,
  input  logic [PKT_PAGES_W-1:0]           pages_i,
  input  logic [BANK_NUM*PAGE_CNT_W-1:0]   free_cnt_i,
  input  logic [BANK_NUM-1:0]              lock_i,
  input  logic [$clog2(BANK_NUM)-1:0]      rr_sram_i,
  input  logic [PORT_W-1:0]                port_i,
  output logic                             found_o,
  output logic [$clog2(BANK_NUM)-1:0]      bank_o
);

  localparam int SW = $clog2(BANK_NUM);

  logic [PAGE_CNT_W-1:0] need;
  logic [BANK_NUM-1:0]   cand;
  logic [PAGE_CNT_W-1:0] best_cnt;
  logic [SW-1:0]         scan;
  logic [SW-1:0]         bank_even;
  logic [SW-1:0]         bank_odd;

  // Candidate bank: unlocked and holding enough free pages for this packet.
  always_comb begin
    need = pages_needed(pages_i);
    for (int b = 0; b < BANK_NUM; b++) begin
      cand[b] = !lock_i[b] && (free_cnt_i[b*PAGE_CNT_W +: PAGE_CNT_W] >= need);
    end
  end

  // Policy-specific choice among the candidates.
  always_comb begin
    // NOTE: every output and temporary gets a value before the case so no branch can infer a latch.
    found_o   = 1'b0;
    bank_o    = '0;
    best_cnt  = '0;
    scan      = '0;
    bank_even = SW'({port_i, 1'b0});
    bank_odd  = SW'({port_i, 1'b1});
    case (mode_i)
      MATCH_STATIC: begin
        if (cand[bank_even]) begin
          found_o = 1'b1;
          bank_o  = bank_even;
        end else if (cand[bank_odd]) begin
          found_o = 1'b1;
          bank_o  = bank_odd;
        end
      end
      MATCH_RR: begin
        for (int i = 0; i < BANK_NUM; i++) begin
          scan = rr_sram_i + SW'(i);
          if (!found_o && cand[scan]) begin
            found_o = 1'b1;
            bank_o  = scan;
          end
        end
      end
      default: begin
        // Strictly-greater comparison keeps ties on the lowest index.
        for (int b = 0; b < BANK_NUM; b++) begin
          if (cand[b] && (!found_o || free_cnt_i[b*PAGE_CNT_W +: PAGE_CNT_W] > best_cnt)) begin
            found_o  = 1'b1;
            bank_o   = SW'(b);
            best_cnt = free_cnt_i[b*PAGE_CNT_W +: PAGE_CNT_W];
          end
        end
      end
    endcase
  end

endmodule

// File: rtl/sram_wr_arbiter.sv
// Write-side SRAM bank arbiter: one port under test per cycle, a one-to-one
// port/bank lock table, registered single-cycle grant pulses.
// Optional feature: define SRAM_ARB_WATCHDOG_EN to force-release locks held
// for 255 cycles and pulse timeout_err; otherwise timeout_err is tied 0.
module sram_wr_arbiter #(
  parameter int PORT_NUM = 16,
  parameter int SRAM_NUM = 32
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic [1:0]                               match_mode,
  input  logic [PORT_NUM-1:0]                      port_req,
  input  logic [PORT_NUM*arb_pkg::PKT_PAGES_W-1:0] port_pkt_pages,
  input  logic [PORT_NUM-1:0]                      port_release,
  input  logic [SRAM_NUM*arb_pkg::PAGE_CNT_W-1:0]  sram_free_cnt,
  output logic                                     grant_vld,
  output logic [$clog2(PORT_NUM)-1:0]              grant_port,
  output logic [$clog2(SRAM_NUM)-1:0]              grant_sram,
  output logic [PORT_NUM-1:0]                      port_locked,
  output logic [PORT_NUM*$clog2(SRAM_NUM)-1:0]     port_sram_idx,
  output logic [PORT_NUM-1:0]                      timeout_err
);

  import arb_pkg::*;

  localparam int PW = $clog2(PORT_NUM);
  localparam int SW = $clog2(SRAM_NUM);

  logic [SRAM_NUM-1:0]         bank_lock_q,   bank_lock_d;
  logic [PORT_NUM-1:0]         port_locked_q, port_locked_d;
  logic [PORT_NUM-1:0][SW-1:0] idx_q,         idx_d;
  logic [PW-1:0]               rr_port_q,     rr_port_d;
  logic [SW-1:0]               rr_sram_q,     rr_sram_d;
  logic                        grant_vld_q,   grant_vld_d;
  logic [PW-1:0]               grant_port_q,  grant_port_d;
  logic [SW-1:0]               grant_sram_q,  grant_sram_d;
`ifdef SRAM_ARB_WATCHDOG_EN
  logic [PORT_NUM-1:0]             timeout_q, timeout_d;
  logic [PORT_NUM-1:0][WDOG_W-1:0] wd_q,      wd_d;
`endif

  logic [PORT_NUM-1:0]    eligible;
  logic                   put_vld;
  logic [PW-1:0]          put_idx;
  logic [PW-1:0]          scan;
  logic [PKT_PAGES_W-1:0] put_pages;
  logic                   bank_found;
  logic [SW-1:0]          bank_idx;

  assign eligible  = port_req & ~port_locked_q;
  assign put_pages = port_pkt_pages[put_idx*PKT_PAGES_W +: PKT_PAGES_W];

  // Port under test: first eligible port at or after rr_port, wrapping.
  always_comb begin
    put_vld = 1'b0;
    put_idx = '0;
    scan    = '0;
    for (int i = 0; i < PORT_NUM; i++) begin
      scan = rr_port_q + PW'(i);
      if (!put_vld && eligible[scan]) begin
        put_vld = 1'b1;
        put_idx = scan;
      end
    end
  end

  // Candidates are judged against the registered lock table, so a bank
  // released this cycle cannot be granted until the next one.
  sram_bank_select #(
    .BANK_NUM (SRAM_NUM),
    .PORT_W   (PW)
  ) u_bank_select (
    .mode_i     (match_mode),
    .pages_i    (put_pages),
    .free_cnt_i (sram_free_cnt),
    .lock_i     (bank_lock_q),
    .rr_sram_i  (rr_sram_q),
    .port_i     (put_idx),
    .found_o    (bank_found),
    .bank_o     (bank_idx)
  );

  // Next state: releases (and watchdog expiry) clear locks, a found candidate sets one.
  always_comb begin
    bank_lock_d   = bank_lock_q;
    port_locked_d = port_locked_q;
    idx_d         = idx_q;
    rr_port_d     = rr_port_q;
    rr_sram_d     = rr_sram_q;
    grant_vld_d   = 1'b0;
    grant_port_d  = grant_port_q;
    grant_sram_d  = grant_sram_q;
`ifdef SRAM_ARB_WATCHDOG_EN
    timeout_d     = '0;
    wd_d          = '0;
`endif
    // A release is honoured only for a port that holds a lock.
    for (int p = 0; p < PORT_NUM; p++) begin
      if (port_locked_q[p]) begin
        if (port_release[p]) begin
          port_locked_d[p]      = 1'b0;
          bank_lock_d[idx_q[p]] = 1'b0;
        end
`ifdef SRAM_ARB_WATCHDOG_EN
        else if (wd_q[p] == WDOG_LAST) begin
          port_locked_d[p]      = 1'b0;
          bank_lock_d[idx_q[p]] = 1'b0;
          timeout_d[p]          = 1'b1;
        end else begin
          wd_d[p] = wd_q[p] + 1'b1;
        end
`endif
      end
    end
    // The pointer moves past the port under test even without a grant,
    // so an unservable head port never stalls the others.
    if (put_vld) begin
      rr_port_d = put_idx + 1'b1;
      if (bank_found) begin
        grant_vld_d            = 1'b1;
        grant_port_d           = put_idx;
        grant_sram_d           = bank_idx;
        port_locked_d[put_idx] = 1'b1;
        bank_lock_d[bank_idx]  = 1'b1;
        idx_d[put_idx]         = bank_idx;
        if (match_mode == MATCH_RR) begin
          rr_sram_d = bank_idx + 1'b1;
        end
      end
    end
  end

  // Lock table, pointers and registered grant outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the lock table is reset explicitly; a power-up lock bit would strand a bank with no owner to release it.
      bank_lock_q   <= '0;
      port_locked_q <= '0;
      idx_q         <= '0;
      rr_port_q     <= '0;
      rr_sram_q     <= '0;
      grant_vld_q   <= 1'b0;
      grant_port_q  <= '0;
      grant_sram_q  <= '0;
    end else begin
      // NOTE: non-blocking updates make every register sample the same pre-edge state.
      bank_lock_q   <= bank_lock_d;
      port_locked_q <= port_locked_d;
      idx_q         <= idx_d;
      rr_port_q     <= rr_port_d;
      rr_sram_q     <= rr_sram_d;
      grant_vld_q   <= grant_vld_d;
      grant_port_q  <= grant_port_d;
      grant_sram_q  <= grant_sram_d;
    end
  end

`ifdef SRAM_ARB_WATCHDOG_EN
  // Per-port lock age counters and the timeout pulse register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_q      <= '0;
      timeout_q <= '0;
    end else begin
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_err = timeout_q;
`else
  assign timeout_err = '0;
`endif

  assign grant_vld     = grant_vld_q;
  assign grant_port    = grant_port_q;
  assign grant_sram    = grant_sram_q;
  assign port_locked   = port_locked_q;
  assign port_sram_idx = idx_q;

endmodule

// File: tb/tb_sram_wr_arbiter.sv
// Self-checking bench for sram_wr_arbiter: a table of single-grant vectors,
// hand-written multi-cycle sequences and a randomized phase, all compared
// against a behavioural ownership model. Honours SRAM_ARB_WATCHDOG_EN.
module tb_sram_wr_arbiter;

  localparam int NP = 16;
  localparam int NB = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [1:0]    match_mode = '0;
  logic [NP-1:0] port_req = '0;
  logic [NP*6-1:0]  port_pkt_pages = '0;
  logic [NP-1:0] port_release = '0;
  logic [NB*12-1:0] sram_free_cnt = '0;
  logic          grant_vld;
  logic [3:0]    grant_port;
  logic [4:0]    grant_sram;
  logic [NP-1:0] port_locked;
  logic [NP*5-1:0] port_sram_idx;
  logic [NP-1:0] timeout_err;

  sram_wr_arbiter dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .match_mode     (match_mode),
    .port_req       (port_req),
    .port_pkt_pages (port_pkt_pages),
    .port_release   (port_release),
    .sram_free_cnt  (sram_free_cnt),
    .grant_vld      (grant_vld),
    .grant_port     (grant_port),
    .grant_sram     (grant_sram),
    .port_locked    (port_locked),
    .port_sram_idx  (port_sram_idx),
    .timeout_err    (timeout_err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model: who owns what ----------------
  int bank_owner[NB];
  int port_bank[NP];
  int age[NP];
  int m_rr_port;
  int m_rr_sram;
  bit exp_gvld;
  int exp_gport;
  int exp_gsram;
  bit [NP-1:0] exp_to;

  function automatic int need_of(input int p);
    int v;
    v = int'(port_pkt_pages[p*6 +: 6]);
    return (v == 0) ? 1 : v;
  endfunction

  function automatic int free_of(input int b);
    return int'(sram_free_cnt[b*12 +: 12]);
  endfunction

  function automatic bit usable(input int b, input int need);
    return (bank_owner[b] < 0) && (free_of(b) >= need);
  endfunction

  task automatic model_reset();
    for (int b = 0; b < NB; b++) bank_owner[b] = -1;
    for (int p = 0; p < NP; p++) begin
      port_bank[p] = -1;
      age[p] = 0;
    end
    m_rr_port = 0;
    m_rr_sram = 0;
    exp_gvld  = 0;
    exp_gport = 0;
    exp_gsram = 0;
    exp_to    = '0;
  endtask

  task automatic free_port(input int p);
    bank_owner[port_bank[p]] = -1;
    port_bank[p] = -1;
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_step();
    int put, bank, need, best, p, b;
    put = -1;
    bank = -1;
    best = 0;
    exp_gvld = 0;
    exp_to = '0;
    for (int i = 0; i < NP; i++) begin
      p = (m_rr_port + i) % NP;
      if (put < 0 && port_req[p] && port_bank[p] < 0) put = p;
    end
    if (put >= 0) begin
      need = need_of(put);
      if (match_mode == 2'd0) begin
        if (usable(2 * put, need)) bank = 2 * put;
        else if (usable(2 * put + 1, need)) bank = 2 * put + 1;
      end else if (match_mode == 2'd2) begin
        for (int i = 0; i < NB; i++) begin
          b = (m_rr_sram + i) % NB;
          if (bank < 0 && usable(b, need)) bank = b;
        end
      end else begin
        for (int k = 0; k < NB; k++) begin
          if (usable(k, need) && (bank < 0 || free_of(k) > best)) begin
            bank = k;
            best = free_of(k);
          end
        end
      end
      m_rr_port = (put + 1) % NP;
    end
    for (int q = 0; q < NP; q++) begin
      if (port_bank[q] >= 0) begin
        if (port_release[q]) free_port(q);
`ifdef SRAM_ARB_WATCHDOG_EN
        else begin
          age[q]++;
          if (age[q] >= 255) begin
            free_port(q);
            exp_to[q] = 1'b1;
          end
        end
`endif
      end
    end
    if (bank >= 0) begin
      bank_owner[bank] = put;
      port_bank[put] = bank;
      age[put] = 0;
      exp_gvld = 1;
      exp_gport = put;
      exp_gsram = bank;
      if (match_mode == 2'd2) m_rr_sram = (bank + 1) % NB;
    end
  endtask

  task automatic compare();
    logic [NP-1:0]   exp_lk;
    logic [NP*5-1:0] exp_idx, act_idx;
    exp_idx = '0;
    act_idx = '0;
    for (int p = 0; p < NP; p++) begin
      exp_lk[p] = (port_bank[p] >= 0);
      if (port_bank[p] >= 0) begin
        exp_idx[p*5 +: 5] = 5'(port_bank[p]);
        act_idx[p*5 +: 5] = port_sram_idx[p*5 +: 5];
      end
    end
    check("grant_vld", grant_vld, exp_gvld);
    if (exp_gvld) begin
      check("grant_port", grant_port, exp_gport);
      check("grant_sram", grant_sram, exp_gsram);
    end
    check("port_locked", port_locked, exp_lk);
    check("port_sram_idx", act_idx, exp_idx);
    check("timeout_err", timeout_err, exp_to);
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    cyc++;
    compare();
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    #1;
    check("rst grant_vld", grant_vld, 0);
    check("rst grant_port", grant_port, 0);
    check("rst grant_sram", grant_sram, 0);
    check("rst port_locked", port_locked, 0);
    check("rst port_sram_idx", port_sram_idx, 0);
    check("rst timeout_err", timeout_err, 0);
    model_reset();
    port_req = '0;
    port_release = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic set_all_free(input int v);
    for (int b = 0; b < NB; b++) sram_free_cnt[b*12 +: 12] = 12'(v);
  endtask

  task automatic set_all_pages(input int v);
    for (int p = 0; p < NP; p++) port_pkt_pages[p*6 +: 6] = 6'(v);
  endtask

  // ---------------- single-grant vectors from reset ----------------
  typedef struct {
    logic [1:0] mode;
    int port;
    int pages;
    int base;
    int b1, v1;
    int b2, v2;
    bit exp_found;
    int exp_bank;
  } vec_t;

  localparam int NV = 12;
  vec_t vec[NV];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int alt_port[4];
    int alt_bank[4];
    int g, t;
    bit seen_to;

    vec[0]  = '{2'd0, 3,  4,  0,    6,  100, -1, 0,   1'b1, 6};
    vec[1]  = '{2'd0, 3,  4,  0,    7,  100, -1, 0,   1'b1, 7};
    vec[2]  = '{2'd0, 3,  4,  3,   -1,  0,   -1, 0,   1'b0, 0};
    vec[3]  = '{2'd1, 0,  20, 10,   5,  900,  9, 900, 1'b1, 5};
    vec[4]  = '{2'd3, 0,  20, 10,   5,  900,  9, 901, 1'b1, 9};
    vec[5]  = '{2'd1, 2,  0,  0,   20,  1,   -1, 0,   1'b1, 20};
    vec[6]  = '{2'd2, 1,  1,  50,  -1,  0,   -1, 0,   1'b1, 0};
    vec[7]  = '{2'd0, 15, 63, 0,   31,  63,  -1, 0,   1'b1, 31};
    vec[8]  = '{2'd1, 5,  63, 62,  -1,  0,   -1, 0,   1'b0, 0};
    vec[9]  = '{2'd1, 8,  1,  2047, 31, 2048, -1, 0,  1'b1, 31};
    vec[10] = '{2'd0, 3,  4,  100,  6,  3,   -1, 0,   1'b1, 7};
    vec[11] = '{2'd2, 9,  40, 39,  17,  40,  -1, 0,   1'b1, 17};

    #2;
    for (int i = 0; i < NV; i++) begin
      reset_dut();
      match_mode = vec[i].mode;
      set_all_free(vec[i].base);
      if (vec[i].b1 >= 0) sram_free_cnt[vec[i].b1*12 +: 12] = 12'(vec[i].v1);
      if (vec[i].b2 >= 0) sram_free_cnt[vec[i].b2*12 +: 12] = 12'(vec[i].v2);
      port_pkt_pages = '0;
      port_pkt_pages[vec[i].port*6 +: 6] = 6'(vec[i].pages);
      port_req[vec[i].port] = 1'b1;
      cycle();
      port_req = '0;
      check($sformatf("vec%0d found", i), grant_vld, vec[i].exp_found);
      if (vec[i].exp_found) begin
        check($sformatf("vec%0d port", i), grant_port, vec[i].port);
        check($sformatf("vec%0d bank", i), grant_sram, vec[i].exp_bank);
        check($sformatf("vec%0d idx", i), port_sram_idx[vec[i].port*5 +: 5], vec[i].exp_bank);
      end
    end

    // Round-robin wrap past locked banks 30/31.
    reset_dut();
    set_all_pages(1);
    match_mode = 2'd1;
    set_all_free(100);
    sram_free_cnt[30*12 +: 12] = 12'd200;
    sram_free_cnt[31*12 +: 12] = 12'd150;
    port_req = 16'h4000;
    cycle();
    check("rrw p14 bank", grant_sram, 30);
    port_req = 16'h2000;
    cycle();
    check("rrw p13 bank", grant_sram, 31);
    match_mode = 2'd2;
    set_all_free(0);
    sram_free_cnt[29*12 +: 12] = 12'd100;
    port_req = 16'h1000;
    cycle();
    check("rrw p12 bank", grant_sram, 29);
    set_all_free(100);
    port_req = 16'h0002;
    cycle();
    check("rrw p1 vld", grant_vld, 1);
    check("rrw p1 bank", grant_sram, 0);
    port_req = 16'h0004;
    cycle();
    check("rrw p2 bank", grant_sram, 1);
    port_req = '0;

    // Two persistent requesters with release after every grant.
    reset_dut();
    set_all_pages(1);
    match_mode = 2'd1;
    set_all_free(100);
    alt_port = '{2, 7, 2, 7};
    alt_bank = '{0, 1, 0, 1};
    port_req = 16'h0084;
    for (int k = 0; k < 4; k++) begin
      cycle();
      port_release = '0;
      check($sformatf("alt%0d vld", k), grant_vld, 1);
      check($sformatf("alt%0d port", k), grant_port, alt_port[k]);
      check($sformatf("alt%0d bank", k), grant_sram, alt_bank[k]);
      if (grant_vld) port_release[grant_port] = 1'b1;
    end
    port_req = '0;
    cycle();
    port_release = '0;

    // Unservable head port must not stall the next one.
    reset_dut();
    match_mode = 2'd1;
    set_all_free(3);
    set_all_pages(0);
    port_pkt_pages[4*6 +: 6] = 6'd5;
    port_pkt_pages[5*6 +: 6] = 6'd2;
    port_req = 16'h0030;
    cycle();
    check("hol p4 no grant", grant_vld, 0);
    cycle();
    check("hol p5 vld", grant_vld, 1);
    check("hol p5 port", grant_port, 5);

    // Release and request on the same locked port: release wins.
    port_req = 16'h0020;
    port_release = 16'h0020;
    cycle();
    port_release = '0;
    check("relwin no grant", grant_vld, 0);
    check("relwin unlocked", port_locked[5], 0);
    cycle();
    check("relwin regrant", grant_vld, 1);
    check("relwin port", grant_port, 5);
    port_req = '0;

    // Lock held with no release: watchdog behaviour.
    reset_dut();
    match_mode = 2'd0;
    set_all_free(100);
    set_all_pages(1);
    port_req = 16'h0001;
    cycle();
    port_req = '0;
    g = cyc;
    check("wdog grant", grant_vld, 1);
    t = -1;
    seen_to = 0;
    for (int k = 0; k < 300; k++) begin
      cycle();
      if (timeout_err[0]) begin
        seen_to = 1;
        if (t < 0) t = cyc;
      end
    end
`ifdef SRAM_ARB_WATCHDOG_EN
    check("wdog latency", t - g, 255);
    check("wdog unlocked", port_locked[0], 0);
`else
    check("wdog absent pulse", seen_to, 0);
    check("wdog absent lock", port_locked[0], 1);
`endif

    // Randomized traffic against the model.
    reset_dut();
    for (int n = 0; n < 2000; n++) begin
      match_mode   = 2'($urandom_range(0, 3));
      port_req     = 16'($urandom & $urandom);
      port_release = 16'($urandom & $urandom & $urandom);
      for (int p = 0; p < NP; p++) port_pkt_pages[p*6 +: 6] = 6'($urandom_range(0, 63));
      for (int b = 0; b < NB; b++) begin
        if ($urandom_range(0, 3) == 0) sram_free_cnt[b*12 +: 12] = 12'($urandom_range(0, 70));
        else sram_free_cnt[b*12 +: 12] = 12'($urandom_range(0, 2048));
      end
      cycle();
    end

    // Reset in the middle of traffic drops every lock; stray releases do nothing.
    reset_dut();
    port_req = '0;
    port_release = 16'hFFFF;
    cycle();
    port_release = '0;
    check("post-rst locked", port_locked, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
